// File: rtl/captura_yuv422.sv
// OV7670 YCbCr 4:2:2 capture front end: turns the camera byte stream into
// one strobed pixel (Y plus the pair's shared Cb/Cr) with x/y coordinates.
module captura_yuv422 #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int ORDER = 0,
  parameter int XW    = 10,
  parameter int YW    = 9
) (
  input  logic          PCLK,
  input  logic          rst_n,
  input  logic          VSYNC,
  input  logic          HREF,
  input  logic [7:0]    D,
  output logic          e_pix,
  output logic [7:0]    Y,
  output logic [7:0]    Cb,
  output logic [7:0]    Cr,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          frame_start,
  output logic          frame_done,
  output logic          err
);

  localparam logic [XW-1:0] L_HMAX = XW'(H_RES);
  localparam logic [YW-1:0] L_VMAX = YW'(V_RES);

  logic [7:0]    r_d;
  logic          r_href, r_vsync, r_hrefD, r_vsyncD;
  logic          r_inFrame;
  logic [1:0]    r_phase;
  logic [7:0]    r_cb, r_cr, r_y0, r_y1;
  logic          r_p1Pend;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_sVld;
  logic [7:0]    r_sY, r_sCb, r_sCr;
  logic [XW-1:0] r_sX;
  logic [YW-1:0] r_sLine;

  logic       w_vsFall, w_vsRise, w_hrefFall, w_accept;
  logic       w_req;
  logic [7:0] w_reqY, w_reqCr;

  assign w_vsFall   = r_vsyncD & ~r_vsync;
  assign w_vsRise   = ~r_vsyncD & r_vsync;
  assign w_hrefFall = r_hrefD & ~r_href;
  assign w_accept   = r_inFrame & ~r_vsync & r_href;

  always_ff @(posedge PCLK or negedge rst_n) begin
    if (!rst_n) begin
      r_d      <= '0;
      r_href   <= 1'b0;
      r_vsync  <= 1'b0;
      r_hrefD  <= 1'b0;
      r_vsyncD <= 1'b0;
    end else begin
      r_d      <= D;
      r_href   <= HREF;
      r_vsync  <= VSYNC;
      r_hrefD  <= r_href;
      r_vsyncD <= r_vsync;
    end
  end

  // A deferred YUYV pixel1 always wins: that cycle's byte is a phase-0 byte, which never emits.
  always_comb begin
    w_req   = 1'b0;
    w_reqY  = r_y0;
    w_reqCr = r_cr;
    if (r_p1Pend) begin
      w_req  = 1'b1;
      w_reqY = r_y1;
    end else if (w_accept) begin
      if (ORDER == 0) begin
        if (r_phase == 2'd2) begin
          w_req   = 1'b1;
          w_reqCr = r_d;
        end else if (r_phase == 2'd3) begin
          w_req  = 1'b1;
          w_reqY = r_d;
        end
      end else if (r_phase == 2'd3) begin
        w_req   = 1'b1;
        w_reqCr = r_d;
      end
    end
  end

  always_ff @(posedge PCLK or negedge rst_n) begin
    if (!rst_n) begin
      r_inFrame   <= 1'b0;
      r_phase     <= 2'd0;
      r_cb        <= '0;
      r_cr        <= '0;
      r_y0        <= '0;
      r_y1        <= '0;
      r_p1Pend    <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_sVld      <= 1'b0;
      r_sY        <= '0;
      r_sCb       <= '0;
      r_sCr       <= '0;
      r_sX        <= '0;
      r_sLine     <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      err         <= 1'b0;
    end else begin
      r_sVld      <= 1'b0;
      r_p1Pend    <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      if (w_vsFall) begin
        frame_start <= 1'b1;
        r_inFrame   <= 1'b1;
        r_x         <= '0;
        r_y         <= '0;
        r_phase     <= 2'd0;
        err         <= 1'b0;
      end else if (w_vsRise) begin
        r_phase <= 2'd0;
        if (r_inFrame) begin
          frame_done <= 1'b1;
          r_inFrame  <= 1'b0;
          if (r_href || (r_phase != 2'd0)) err <= 1'b1;
        end
      end else if (r_inFrame && !r_vsync) begin
        if (w_req) begin
          if ((r_x < L_HMAX) && (r_y < L_VMAX)) begin
            r_sVld  <= 1'b1;
            r_sY    <= w_reqY;
            r_sCb   <= r_cb;
            r_sCr   <= w_reqCr;
            r_sX    <= r_x;
            r_sLine <= r_y;
          end else begin
            err <= 1'b1;
          end
          if (r_x < L_HMAX) r_x <= r_x + XW'(1);
        end
        if (w_accept) begin
          r_phase <= r_phase + 2'd1;
          if (ORDER == 0) begin
            case (r_phase)
              2'd0:    r_cb <= r_d;
              2'd1:    r_y0 <= r_d;
              2'd2:    r_cr <= r_d;
              default: ;
            endcase
          end else begin
            case (r_phase)
              2'd0: r_y0 <= r_d;
              2'd1: r_cb <= r_d;
              2'd2: r_y1 <= r_d;
              default: begin
                r_cr     <= r_d;
                r_p1Pend <= 1'b1;
              end
            endcase
          end
        end
        // Line end is applied last so it overrides the x increment of a pending pixel1.
        if (w_hrefFall) begin
          r_x     <= '0;
          r_phase <= 2'd0;
          if (r_y < L_VMAX) r_y <= r_y + YW'(1);
          if (r_phase != 2'd0) err <= 1'b1;
        end
      end else begin
        r_phase <= 2'd0;
      end
    end
  end

  always_ff @(posedge PCLK or negedge rst_n) begin
    if (!rst_n) begin
      e_pix <= 1'b0;
      Y     <= '0;
      Cb    <= '0;
      Cr    <= '0;
      x     <= '0;
      y     <= '0;
    end else begin
      e_pix <= r_sVld;
      if (r_sVld) begin
        Y  <= r_sY;
        Cb <= r_sCb;
        Cr <= r_sCr;
        x  <= r_sX;
        y  <= r_sLine;
      end
    end
  end

endmodule

// File: tb/tb_captura_yuv422.sv
// Scoreboard bench: a UYVY and a YUYV instance get the same pixels in their own byte
// order, so one reference model feeds both expectation queues.
module tb_captura_yuv422;

  localparam int H = 4;
  localparam int V = 3;

  typedef struct packed {
    logic [7:0] py;
    logic [7:0] pcb;
    logic [7:0] pcr;
    logic [9:0] px;
    logic [8:0] pline;
  } pix_t;

  logic       PCLK = 1'b0;
  logic       rst_n, VSYNC, HREF;
  logic [7:0] d0, d1;

  logic       eP    [2];
  logic [7:0] oY    [2];
  logic [7:0] oCb   [2];
  logic [7:0] oCr   [2];
  logic [9:0] oX    [2];
  logic [8:0] oLine [2];
  logic       fsP   [2];
  logic       fdP   [2];
  logic       errP  [2];

  pix_t q0[$];
  pix_t q1[$];

  int nVec = 0, nFail = 0;
  int pixCnt[2] = '{0, 0};
  int fsCnt[2]  = '{0, 0};
  int fdCnt[2]  = '{0, 0};

  int bx = 0, by = 0;
  bit inFrame = 0, expErr = 0, linePartial = 0;
  int expStart = 0, expDone = 0, expPix = 0;

  always #5 PCLK = ~PCLK;

  captura_yuv422 #(.H_RES(H), .V_RES(V), .ORDER(0), .XW(10), .YW(9)) dutUyvy (
    .PCLK(PCLK), .rst_n(rst_n), .VSYNC(VSYNC), .HREF(HREF), .D(d0),
    .e_pix(eP[0]), .Y(oY[0]), .Cb(oCb[0]), .Cr(oCr[0]), .x(oX[0]), .y(oLine[0]),
    .frame_start(fsP[0]), .frame_done(fdP[0]), .err(errP[0]));

  captura_yuv422 #(.H_RES(H), .V_RES(V), .ORDER(1), .XW(10), .YW(9)) dutYuyv (
    .PCLK(PCLK), .rst_n(rst_n), .VSYNC(VSYNC), .HREF(HREF), .D(d1),
    .e_pix(eP[1]), .Y(oY[1]), .Cb(oCb[1]), .Cr(oCr[1]), .x(oX[1]), .y(oLine[1]),
    .frame_start(fsP[1]), .frame_done(fdP[1]), .err(errP[1]));

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic monitorDut(input int k);
    pix_t act, exp;
    if (eP[k]) begin
      pixCnt[k]++;
      act = '{oY[k], oCb[k], oCr[k], oX[k], oLine[k]};
      if ((k == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
        nVec++;
        nFail++;
        $display("[TB] FAIL unexpectedPix dut%0d: got %0h, expected none", k, act);
      end else begin
        exp = (k == 0) ? q0.pop_front() : q1.pop_front();
        checkOutput($sformatf("pix dut%0d", k), 64'(act), 64'(exp));
      end
    end
    if (fsP[k]) fsCnt[k]++;
    if (fdP[k]) fdCnt[k]++;
  endtask

  always @(negedge PCLK) monitorDut(0);
  always @(negedge PCLK) monitorDut(1);

  task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1);
    @(posedge PCLK); #1;
    HREF = 1'b1;
    d0   = b0;
    d1   = b1;
  endtask

  task automatic modelPixel(input logic [7:0] py, input logic [7:0] pcb, input logic [7:0] pcr);
    pix_t p;
    if (!inFrame) return;
    if (bx < H && by < V) begin
      p = '{py, pcb, pcr, 10'(bx), 9'(by)};
      q0.push_back(p);
      q1.push_back(p);
      expPix++;
    end else begin
      expErr = 1;
    end
    if (bx < H) bx++;
  endtask

  task automatic sendPair(input logic [7:0] y0, input logic [7:0] y1,
                          input logic [7:0] cb, input logic [7:0] cr);
    modelPixel(y0, cb, cr);
    modelPixel(y1, cb, cr);
    applyStimulus(cb, y0);
    applyStimulus(y0, cb);
    applyStimulus(cr, y1);
    applyStimulus(y1, cr);
  endtask

  task automatic sendPartial(input logic [7:0] y0, input logic [7:0] cb);
    applyStimulus(cb, y0);
    applyStimulus(y0, cb);
    linePartial = 1;
  endtask

  task automatic endLine();
    @(posedge PCLK); #1;
    HREF = 1'b0;
    repeat (5) @(posedge PCLK);
    #1;
    if (inFrame) begin
      bx = 0;
      if (by < V) by++;
      if (linePartial) expErr = 1;
    end
    linePartial = 0;
  endtask

  task automatic startFrame();
    @(posedge PCLK); #1;
    VSYNC = 1'b0;
    repeat (4) @(posedge PCLK);
    #1;
    inFrame = 1; bx = 0; by = 0; expErr = 0;
    expStart++;
  endtask

  task automatic endFrame();
    @(posedge PCLK); #1;
    VSYNC = 1'b1;
    repeat (4) @(posedge PCLK);
    #1;
    if (inFrame) expDone++;
    inFrame = 0;
  endtask

  task automatic checkErr(input string name);
    for (int k = 0; k < 2; k++)
      checkOutput($sformatf("%s dut%0d", name, k), 64'(errP[k]), 64'(expErr));
  endtask

  task automatic checkAllZero(input string name);
    for (int k = 0; k < 2; k++)
      checkOutput($sformatf("%s dut%0d", name, k),
                  64'({eP[k], oY[k], oCb[k], oCr[k], oX[k], oLine[k], fsP[k], fdP[k], errP[k]}),
                  64'(0));
  endtask

  initial begin
    int before0, before1;
    rst_n = 1'b0; VSYNC = 1'b1; HREF = 1'b0; d0 = '0; d1 = '0;
    repeat (3) @(posedge PCLK);
    #1;
    checkAllZero("resetState");
    rst_n = 1'b1;
    repeat (3) @(posedge PCLK);

    // Single pair: UYVY bytes 80,10,90,20 / YUYV bytes 10,80,20,90.
    startFrame();
    checkErr("errAfterStart");
    sendPair(8'd10, 8'd20, 8'd80, 8'd90);
    endLine();
    endFrame();
    checkErr("errSingleLine");

    // Complete small frame of ramp data; the last pixel is x=H-1, y=V-1.
    before0 = pixCnt[0];
    before1 = pixCnt[1];
    startFrame();
    for (int r = 0; r < V; r++) begin
      for (int p = 0; p < H / 2; p++)
        sendPair(8'(r * 16 + p * 2), 8'(r * 16 + p * 2 + 1), 8'(128 + r), 8'(64 + p));
      endLine();
    end
    endFrame();
    checkErr("errFullFrame");
    checkOutput("fullFramePix dut0", 64'(pixCnt[0] - before0), 64'(H * V));
    checkOutput("fullFramePix dut1", 64'(pixCnt[1] - before1), 64'(H * V));

    // Full line plus two trailing bytes, then the next frame_start must clear err.
    startFrame();
    sendPair(8'd1, 8'd2, 8'd100, 8'd200);
    sendPair(8'd3, 8'd4, 8'd101, 8'd201);
    sendPartial(8'd5, 8'd102);
    endLine();
    checkErr("errTrailingBytes");
    endFrame();
    startFrame();
    checkErr("errClearedOnStart");

    // Overflowing line, partial-group line, then lines past V_RES.
    sendPair(8'd20, 8'd21, 8'd30, 8'd31);
    sendPair(8'd22, 8'd23, 8'd32, 8'd33);
    sendPair(8'd24, 8'd25, 8'd34, 8'd35);
    endLine();
    checkErr("errXOverflow");
    sendPair(8'd40, 8'd41, 8'd50, 8'd51);
    sendPartial(8'd42, 8'd52);
    endLine();
    sendPair(8'd60, 8'd61, 8'd70, 8'd71);
    endLine();
    sendPair(8'd80, 8'd81, 8'd90, 8'd91);
    endLine();
    endFrame();
    checkErr("errAfterOverflowFrame");

    // Reset pulse mid-line: nothing comes out until the next VSYNC fall.
    startFrame();
    sendPair(8'd7, 8'd8, 8'd9, 8'd6);
    endLine();
    applyStimulus(8'd111, 8'd112);
    applyStimulus(8'd112, 8'd111);
    @(posedge PCLK); #1;
    rst_n = 1'b0;
    #2;
    checkAllZero("midLineReset");
    @(posedge PCLK); #1;
    rst_n = 1'b1;
    inFrame = 0; expErr = 0; bx = 0; by = 0; linePartial = 0;
    sendPair(8'd150, 8'd151, 8'd152, 8'd153);
    endLine();
    checkErr("errAfterReset");
    endFrame();
    startFrame();
    sendPair(8'd11, 8'd22, 8'd33, 8'd44);
    endLine();
    endFrame();

    repeat (4) @(posedge PCLK);
    #1;
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("frameStartCount dut%0d", k), 64'(fsCnt[k]), 64'(expStart));
      checkOutput($sformatf("frameDoneCount dut%0d", k), 64'(fdCnt[k]), 64'(expDone));
      checkOutput($sformatf("pixCount dut%0d", k), 64'(pixCnt[k]), 64'(expPix));
    end
    checkOutput("pendingQueue dut0", 64'(q0.size()), 64'(0));
    checkOutput("pendingQueue dut1", 64'(q1.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
